// File: rtl/ntt_pkg.sv
// Shared types, moduli, Barrett constants and small modular helpers for the NTT datapath.
package ntt_pkg;

    localparam int unsigned LATENCY = 3;

    localparam logic [22:0] Q_KYBER     = 23'd3329;
    localparam logic [22:0] Q_DILITHIUM = 23'd8380417;

    // Barrett shift k and m = floor(2^k / q); k is chosen so every product of two
    // canonical operands is below 2^k, which bounds the quotient estimate error to one.
    localparam int unsigned BARRETT_K_KYBER     = 24;
    localparam int unsigned BARRETT_K_DILITHIUM = 46;
    localparam logic [23:0] BARRETT_M_KYBER     = 24'((64'd1 << 24) / 64'd3329);
    localparam logic [23:0] BARRETT_M_DILITHIUM = 24'((64'd1 << 46) / 64'd8380417);

    typedef logic [22:0] coeff_t;

    typedef enum logic {DILITHIUM = 1'b0, KYBER = 1'b1} red_sel_e;
    typedef enum logic {CT = 1'b0, GS = 1'b1} bf_sel_e;

    function automatic logic [23:0] modulus(red_sel_e sel);
        return (sel == KYBER) ? 24'(Q_KYBER) : 24'(Q_DILITHIUM);
    endfunction

    // [0, 2q) -> [0, q) by one conditional subtraction.
    function automatic coeff_t reduce_2q(logic [23:0] x, red_sel_e sel);
        logic [23:0] q;
        q = modulus(sel);
        return (x >= q) ? coeff_t'(x - q) : coeff_t'(x);
    endfunction

    function automatic coeff_t mod_add(coeff_t x, coeff_t y, red_sel_e sel);
        logic [23:0] q;
        logic [23:0] s;
        q = modulus(sel);
        s = 24'(x) + 24'(y);
        return (s >= q) ? coeff_t'(s - q) : coeff_t'(s);
    endfunction

    function automatic coeff_t mod_sub(coeff_t x, coeff_t y, red_sel_e sel);
        logic [23:0] q;
        q = modulus(sel);
        return (x >= y) ? coeff_t'(x - y) : coeff_t'(24'(x) + q - 24'(y));
    endfunction

endpackage

// File: rtl/ntt_butterfly_if.sv
// Operand/result bundle between the NTT engine and the butterfly.
interface ntt_butterfly_if;
    import ntt_pkg::*;

    logic        valid_i;
    logic [23:0] a_i;
    logic [23:0] b_i;
    coeff_t      twiddle_i;
    logic        sel_red_i;
    logic        sel_butterfly_i;

    logic        valid_o;
    coeff_t      a_out_o;
    coeff_t      b_out_o;

    modport master (
        output valid_i, a_i, b_i, twiddle_i, sel_red_i, sel_butterfly_i,
        input  valid_o, a_out_o, b_out_o
    );

    modport slave (
        input  valid_i, a_i, b_i, twiddle_i, sel_red_i, sel_butterfly_i,
        output valid_o, a_out_o, b_out_o
    );

endinterface

// File: rtl/mod_mul_barrett.sv
// One-cycle registered modular multiplier, Barrett reduction selectable per operation.
module mod_mul_barrett
    import ntt_pkg::*;
(
    input  logic     clk_i,
    input  logic     rst_i,
    input  coeff_t   a_i,
    input  coeff_t   b_i,
    input  red_sel_e sel_red_i,
    output coeff_t   res_o
);

    logic [23:0] q;
    logic [45:0] prod;
    logic [69:0] est;
    logic [22:0] qhat;
    logic [23:0] r;
    coeff_t      res_d;
    coeff_t      res_q;

    // Product, quotient estimate, remainder in [0, 2q), final conditional subtraction.
    always_comb begin
        q    = modulus(sel_red_i);
        prod = 46'(a_i) * 46'(b_i);
        if (sel_red_i == KYBER) begin
            est  = 70'(prod) * 70'(BARRETT_M_KYBER);
            qhat = 23'(est >> BARRETT_K_KYBER);
        end else begin
            est  = 70'(prod) * 70'(BARRETT_M_DILITHIUM);
            qhat = 23'(est >> BARRETT_K_DILITHIUM);
        end
        r     = 24'(prod - 46'(qhat) * 46'(q));
        res_d = (r >= q) ? coeff_t'(r - q) : coeff_t'(r);
    end

    // Result register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            res_q <= '0;
        end else begin
            res_q <= res_d;
        end
    end

    assign res_o = res_q;

endmodule

// File: rtl/ntt_butterfly.sv
// Three-stage CT/GS modular butterfly for Kyber and Dilithium.
module ntt_butterfly
    import ntt_pkg::*;
(
    input logic            clk_i,
    input logic            rst_i,
    ntt_butterfly_if.slave bus
);

    red_sel_e in_red;
    bf_sel_e  in_bf;
    coeff_t   in_a_red;
    coeff_t   in_b_red;
    coeff_t   s1_a_d;
    coeff_t   s1_x_d;

    logic     s1_valid_q;
    coeff_t   s1_a_q;
    coeff_t   s1_x_q;
    coeff_t   s1_w_q;
    red_sel_e s1_red_q;
    bf_sel_e  s1_bf_q;

    coeff_t   mul_res;

    logic     s2_valid_q;
    coeff_t   s2_a_q;
    red_sel_e s2_red_q;
    bf_sel_e  s2_bf_q;

    coeff_t   out_a_d;
    coeff_t   out_b_d;
    logic     valid_q;
    coeff_t   out_a_q;
    coeff_t   out_b_q;

    // Stage 1: reduce inputs to [0, q); GS does its add/sub before the multiply.
    always_comb begin
        in_red   = red_sel_e'(bus.sel_red_i);
        in_bf    = bf_sel_e'(bus.sel_butterfly_i);
        in_a_red = reduce_2q(bus.a_i, in_red);
        in_b_red = reduce_2q(bus.b_i, in_red);
        s1_a_d   = in_a_red;
        s1_x_d   = in_b_red;
        if (in_bf == GS) begin
            s1_a_d = mod_add(in_a_red, in_b_red, in_red);
            s1_x_d = mod_sub(in_a_red, in_b_red, in_red);
        end
    end

    // Stage 1 registers; data only loads on a valid operation.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_x_q     <= '0;
            s1_w_q     <= '0;
            s1_red_q   <= DILITHIUM;
            s1_bf_q    <= CT;
        end else begin
            s1_valid_q <= bus.valid_i;
            if (bus.valid_i) begin
                s1_a_q   <= s1_a_d;
                s1_x_q   <= s1_x_d;
                s1_w_q   <= bus.twiddle_i;
                s1_red_q <= in_red;
                s1_bf_q  <= in_bf;
            end
        end
    end

    // Stage 2: w*b (CT) or w*(a-b) (GS).
    mod_mul_barrett u_mul (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .a_i       (s1_w_q),
        .b_i       (s1_x_q),
        .sel_red_i (s1_red_q),
        .res_o     (mul_res)
    );

    // Stage 2 side-band registers travelling alongside the multiplier.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s2_valid_q <= 1'b0;
            s2_a_q     <= '0;
            s2_red_q   <= DILITHIUM;
            s2_bf_q    <= CT;
        end else begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_a_q   <= s1_a_q;
                s2_red_q <= s1_red_q;
                s2_bf_q  <= s1_bf_q;
            end
        end
    end

    // Stage 3: CT add/sub around the product; GS passes sum and product through.
    always_comb begin
        out_a_d = s2_a_q;
        out_b_d = mul_res;
        if (s2_bf_q == CT) begin
            out_a_d = mod_add(s2_a_q, mul_res, s2_red_q);
            out_b_d = mod_sub(s2_a_q, mul_res, s2_red_q);
        end
    end

    // Output registers; results hold while no valid operation arrives.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            out_a_q <= '0;
            out_b_q <= '0;
        end else begin
            valid_q <= s2_valid_q;
            if (s2_valid_q) begin
                out_a_q <= out_a_d;
                out_b_q <= out_b_d;
            end
        end
    end

    assign bus.valid_o = valid_q;
    assign bus.a_out_o = out_a_q;
    assign bus.b_out_o = out_b_q;

endmodule

// File: tb/tb_ntt_butterfly.sv
// Scoreboard bench for ntt_butterfly: expected results queued at issue, observed
// results queued by a monitor, compared in order together with their arrival cycle.
module tb_ntt_butterfly;

    localparam longint QK = 3329;
    localparam longint QD = 8380417;

    typedef struct {
        logic [22:0] a;
        logic [22:0] b;
        int          cyc;
    } res_t;

    logic clk;
    logic rst;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    res_t exp_q[$];
    res_t obs_q[$];

    ntt_butterfly_if bus ();

    ntt_butterfly u_dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: record every valid result with the cycle it appeared in.
    always @(negedge clk) begin
        if (!rst && bus.valid_o === 1'b1) begin
            obs_q.push_back('{a: bus.a_out_o, b: bus.b_out_o, cyc: cyc});
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void model(input longint a, input longint b, input longint w,
                                  input bit kyb, input bit gs,
                                  output longint ea, output longint eb);
        longint q, ra, rb, t;
        q  = kyb ? QK : QD;
        ra = a % q;
        rb = b % q;
        if (!gs) begin
            t  = (w * rb) % q;
            ea = (ra + t) % q;
            eb = (ra - t + q) % q;
        end else begin
            ea = (ra + rb) % q;
            eb = (((ra - rb + q) % q) * w) % q;
        end
    endfunction

    // Drive one operation for a single cycle and queue its expected result.
    task automatic issue(input logic [23:0] a, input logic [23:0] b, input logic [22:0] w,
                         input bit kyb, input bit gs,
                         input logic [22:0] ea, input logic [22:0] eb);
        @(negedge clk);
        bus.valid_i         = 1'b1;
        bus.a_i             = a;
        bus.b_i             = b;
        bus.twiddle_i       = w;
        bus.sel_red_i       = kyb;
        bus.sel_butterfly_i = gs;
        exp_q.push_back('{a: ea, b: eb, cyc: cyc + 3});
    endtask

    task automatic issue_model(input longint a, input longint b, input longint w,
                               input bit kyb, input bit gs);
        longint ea, eb;
        model(a, b, w, kyb, gs, ea, eb);
        issue(24'(a), 24'(b), 23'(w), kyb, gs, 23'(ea), 23'(eb));
    endtask

    task automatic idle();
        @(negedge clk);
        bus.valid_i = 1'b0;
    endtask

    // Bounded wait for all queued results plus a few cycles to expose stray pulses.
    task automatic wait_results();
        for (int i = 0; i < 60 && obs_q.size() < exp_q.size(); i++) @(posedge clk);
        repeat (4) @(posedge clk);
    endtask

    task automatic test_reset();
        rst                 = 1'b1;
        bus.valid_i         = 1'b0;
        bus.a_i             = '0;
        bus.b_i             = '0;
        bus.twiddle_i       = '0;
        bus.sel_red_i       = 1'b0;
        bus.sel_butterfly_i = 1'b0;
        repeat (3) @(negedge clk);
        vectors += 3;
        if (bus.valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_valid: got %b, required 0", bus.valid_o);
        end
        if (bus.a_out_o !== 23'd0) begin
            miscompares++;
            $display("FAIL reset_a: got %0d, required 0", bus.a_out_o);
        end
        if (bus.b_out_o !== 23'd0) begin
            miscompares++;
            $display("FAIL reset_b: got %0d, required 0", bus.b_out_o);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_directed();
        res_t e, o;
        issue(24'd3210, 24'd19, 23'd281, 1'b1, 1'b0, 23'd1891, 23'd1200);
        idle();
        issue(24'd1891, 24'd1200, 23'd281, 1'b1, 1'b1, 23'd3091, 23'd1089);
        idle();
        idle();
        issue(24'd8297430, 24'd7194, 23'd400232, 1'b0, 1'b0, 23'd4702990, 23'd3511453);
        idle();
        issue(24'd4702990, 24'd3511453, 23'd400232, 1'b0, 1'b1, 23'd8214443, 23'd3607199);
        idle();
        wait_results();
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (obs_q.size() == 0) begin
                miscompares++;
                $display("FAIL directed: no result, required a=%0d b=%0d cycle %0d",
                         e.a, e.b, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o.a !== e.a || o.b !== e.b || o.cyc != e.cyc) begin
                    miscompares++;
                    $display("FAIL directed: got a=%0d b=%0d cycle %0d, required a=%0d b=%0d cycle %0d",
                             o.a, o.b, o.cyc, e.a, e.b, e.cyc);
                end
            end
        end
        vectors++;
        if (obs_q.size() != 0) begin
            miscompares++;
            $display("FAIL directed_extra: got %0d stray results, required 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_back_to_back();
        res_t e, o;
        int   first;
        issue(24'd3210, 24'd19, 23'd281, 1'b1, 1'b0, 23'd1891, 23'd1200);
        first = exp_q[0].cyc;
        issue(24'd1891, 24'd1200, 23'd281, 1'b1, 1'b1, 23'd3091, 23'd1089);
        issue(24'd8297430, 24'd7194, 23'd400232, 1'b0, 1'b0, 23'd4702990, 23'd3511453);
        issue(24'd4702990, 24'd3511453, 23'd400232, 1'b0, 1'b1, 23'd8214443, 23'd3607199);
        idle();
        wait_results();
        for (int k = 0; exp_q.size() != 0; k++) begin
            e = exp_q.pop_front();
            vectors++;
            if (obs_q.size() == 0) begin
                miscompares++;
                $display("FAIL back_to_back: no result %0d, required a=%0d b=%0d", k, e.a, e.b);
            end else begin
                o = obs_q.pop_front();
                if (o.a !== e.a || o.b !== e.b || o.cyc != first + k) begin
                    miscompares++;
                    $display("FAIL back_to_back: got a=%0d b=%0d cycle %0d, required a=%0d b=%0d cycle %0d",
                             o.a, o.b, o.cyc, e.a, e.b, first + k);
                end
            end
        end
        vectors++;
        if (obs_q.size() != 0) begin
            miscompares++;
            $display("FAIL back_to_back_extra: got %0d stray results, required 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_reset_inflight();
        issue(24'd3210, 24'd19, 23'd281, 1'b1, 1'b0, 23'd1891, 23'd1200);
        issue(24'd100, 24'd100, 23'd7, 1'b0, 1'b1, 23'd200, 23'd0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        bus.valid_i = 1'b0;
        #1;
        vectors += 3;
        if (bus.valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_valid: got %b, required 0", bus.valid_o);
        end
        if (bus.a_out_o !== 23'd0) begin
            miscompares++;
            $display("FAIL midreset_a: got %0d, required 0", bus.a_out_o);
        end
        if (bus.b_out_o !== 23'd0) begin
            miscompares++;
            $display("FAIL midreset_b: got %0d, required 0", bus.b_out_o);
        end
        exp_q.delete();
        obs_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (8) @(posedge clk);
        vectors++;
        if (obs_q.size() != 0) begin
            miscompares++;
            $display("FAIL midreset_release: got %0d valid results, required 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_edges_random();
        res_t   e, o;
        longint q;
        bit     kyb;
        issue(24'd6657, 24'd0, 23'd0, 1'b1, 1'b0, 23'd3328, 23'd3328);
        issue(24'd100, 24'd100, 23'd400232, 1'b0, 1'b1, 23'd200, 23'd0);
        issue_model(QK, QK, 5, 1'b1, 1'b0);
        issue_model(2 * QK - 1, QK, QK - 1, 1'b1, 1'b1);
        issue_model(2 * QD - 1, QD, QD - 1, 1'b0, 1'b0);
        issue_model(QD - 1, 2 * QD - 1, QD - 1, 1'b0, 1'b1);
        for (int n = 0; n < 48; n++) begin
            if ($urandom_range(0, 3) == 0) idle();
            kyb = 1'($urandom_range(0, 1));
            q   = kyb ? QK : QD;
            issue_model(longint'($urandom_range(0, 32'(2 * q - 1))),
                        longint'($urandom_range(0, 32'(2 * q - 1))),
                        longint'($urandom_range(0, 32'(q - 1))),
                        kyb, 1'($urandom_range(0, 1)));
        end
        idle();
        wait_results();
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (obs_q.size() == 0) begin
                miscompares++;
                $display("FAIL edge_random: no result, required a=%0d b=%0d cycle %0d",
                         e.a, e.b, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o.a !== e.a || o.b !== e.b || o.cyc != e.cyc) begin
                    miscompares++;
                    $display("FAIL edge_random: got a=%0d b=%0d cycle %0d, required a=%0d b=%0d cycle %0d",
                             o.a, o.b, o.cyc, e.a, e.b, e.cyc);
                end
            end
        end
        vectors++;
        if (obs_q.size() != 0) begin
            miscompares++;
            $display("FAIL edge_random_extra: got %0d stray results, required 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_inflight();
        test_edges_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ntt_butterfly.md
Name: ntt_butterfly

Overview:
- Pipelined modular butterfly for NTT/INTT datapaths shared by Kyber (q = 3329) and Dilithium (q = 8380417).
- Performs either a Cooley-Tukey (forward NTT) or a Gentleman-Sande (inverse NTT) butterfly on two coefficients and one twiddle factor.
- Modulus and butterfly type are selected per operation.
- Sits between the coefficient RAM read ports and write-back in the NTT engine.

Parameters:
- LATENCY, 3, cycles from the sampling edge of valid_i to valid_o; fixed, not to be overridden.

Ports:
- clk_i  in  1  clock, all registers rising-edge
- rst_i  in  1  asynchronous active-high reset
- valid_i  in  1  input operands valid this cycle
- a_i  in  24  coefficient a, in range [0, 2q)
- b_i  in  24  coefficient b, in range [0, 2q)
- twiddle_i  in  23  twiddle w, in range [0, q), plain (non-Montgomery) domain
- sel_red_i  in  1  modulus select: 1 = Kyber q=3329, 0 = Dilithium q=8380417
- sel_butterfly_i  in  1  0 = Cooley-Tukey, 1 = Gentleman-Sande
- valid_o  out  1  outputs valid
- a_out_o  out  23  result a', fully reduced to [0, q)
- b_out_o  out  23  result b', fully reduced to [0, q)

Behaviour:
- Arithmetic, all results mod q:
  - CT: t = w*b; a' = a + t; b' = a - t.
  - GS: a' = a + b; b' = (a - b)*w.
  - No scaling by 1/2 and no Montgomery factor.
- Inputs a, b are first reduced from [0, 2q) to [0, q) by one conditional subtraction.
- Subtractions add q when the result would be negative.
- Outputs are always canonical, in [0, q).
- Multiplication: 23x23 -> 46-bit product, reduced by Barrett reduction with per-modulus constants, then a final conditional subtraction.
- Pipeline:
  - Stage 1: input reduction; GS add/sub.
  - Stage 2: modular multiply (CT: w*b; GS: w*(a-b)).
  - Stage 3: CT add/sub; output registers.
- Timing:
  - Fully pipelined; one new operation accepted every cycle.
  - Results appear exactly LATENCY cycles after valid_i is sampled high.
  - sel_red_i and sel_butterfly_i are sampled with the data and travel down the pipeline, so mixed modes back-to-back are legal.
- When valid_i is low, the stage valid bit clears. a_out_o and b_out_o hold their last values; only valid_o is meaningful.
- Reset:
  - valid_o = 0, a_out_o = 0, b_out_o = 0; all internal valid bits cleared.
  - Asserting reset mid-operation discards in-flight operations. No valid_o pulse follows release for operations issued before reset.
- Boundary cases:
  - a = b: GS gives b' = 0.
  - w = 0: CT gives a' = b' = reduced a.
  - Inputs equal to q or 2q-1 reduce correctly.
  - Kyber inputs use the same 24-bit ports with upper bits zero.
  - Inputs outside [0, 2q) or w >= q: outputs unspecified, valid timing unaffected.

Decomposition:
- Package ntt_pkg holds:
  - Q_KYBER = 3329 and Q_DILITHIUM = 8380417;
  - Barrett constants for each modulus;
  - coeff_t (logic [22:0]);
  - enums red_sel_e (DILITHIUM = 0, KYBER = 1) and bf_sel_e (CT = 0, GS = 1).
- One sub-module: mod_mul_barrett.
  - 1-cycle registered modular multiplier taking operands and the modulus select.
  - Reused by the butterfly and other NTT blocks.

Test Plan:
- Kyber CT: a=3210, b=19, w=281, sel_red=1, sel_bf=0 -> after 3 cycles a'=1891, b'=1200.
- Kyber GS: a=1891, b=1200, w=281, sel_red=1, sel_bf=1 -> a'=3091, b'=1089.
- Dilithium CT: a=8297430, b=7194, w=400232, sel_red=0, sel_bf=0 -> a'=4702990, b'=3511453.
- Dilithium GS: a=4702990, b=3511453, w=400232, sel_red=0, sel_bf=1 -> a'=8214443, b'=3607199.
- Back-to-back streaming:
  - Stimulus: the four vectors above issued on consecutive cycles with valid_i=1.
  - Response: valid_o high for 4 consecutive cycles starting 3 cycles after the first, with results in issue order.
- Reset and edge values:
  - Assert rst_i while two operations are in flight -> valid_o=0, outputs 0 immediately, no valid_o after release.
  - Kyber CT a=6657, b=0, w=0 -> a'=b'=3328.
  - Dilithium GS a=b=100 -> a'=200, b'=0.
